inst_fetch_unit: RTL and testbench

//  Initiator side of the instruction-memory read interface. Holds the PC and issues

---
 rtl/inst_fetch_unit.sv | 162 ++++++++++++++++
 tb/tb_inst_fetch_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: instruction fetch front end.
//   Holds the PC and issues reads to inst_mem. Each word returns one cycle after
//   its read and is captured, together with the address it came from, into a
//   small prefetch FIFO. Decode drains the FIFO through a valid/ready handshake.
//   A branch redirect flushes everything and restarts fetch at redirect_pc.
//
// Configuration macro: FETCH_HALT_EN
//   When defined, a captured word whose opcode equals HALT_OPCODE stops fetch.
//   The HALT word itself is still delivered. Only a redirect or a reset leaves HALT.
//   When undefined, every opcode is fetched through and halted is tied low.
//
// Ports
//   clk          in   1   clock, all state on posedge
//   Reset_n      in   1   asynchronous active-low reset
//   fetch_en     in   1   permission to issue new memory reads
//   mem_addr     out  8   read address to inst_mem (the PC register)
//   mem_rd       out  1   read strobe; data returns on mem_data next cycle
//   mem_data     in   25  instruction word from inst_mem
//   inst_valid   out  1   FIFO head valid
//   inst_ready   in   1   decode accepts the head this cycle
//   inst_data    out  25  head word (0 when empty)
//   inst_pc      out  8   fetch address of the head word (0 when empty)
//   redirect     in   1   taken branch: flush and restart at redirect_pc
//   redirect_pc  in   8   new fetch address
//   halted       out  1   fetch stopped on a HALT word

module inst_fetch_unit #(
    parameter logic [7:0]  RESET_PC    = 8'h00,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter logic [4:0]  HALT_OPCODE = 5'b11111
) (
    input  logic        clk,
    input  logic        Reset_n,
    input  logic        fetch_en,
    output logic [7:0]  mem_addr,
    output logic        mem_rd,
    input  logic [24:0] mem_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [24:0] inst_data,
    output logic [7:0]  inst_pc,
    input  logic        redirect,
    input  logic [7:0]  redirect_pc,
    output logic        halted
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW:0]   DEPTH_C = (CW + 1)'(FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [CW-1:0] CNT_ONE = 1;

    typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

    state_e state_q, state_d;

    logic [7:0]    pc_q;
    logic [7:0]    tag_q;
    logic          inflight_q;
    logic [24:0]   fifo_data_q [FIFO_DEPTH];
    logic [7:0]    fifo_pc_q   [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;

    logic          pop_req;
    logic          pop;
    logic          push;
    logic          halt_hit;
    logic [CW:0]   occupancy;

    assign inst_valid = (count_q != '0);
    assign inst_data  = inst_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign inst_pc    = inst_valid ? fifo_pc_q[rd_ptr_q]   : '0;
    assign mem_addr   = pc_q;

    // Decode's accept is ignored while a redirect flushes the FIFO.
    assign pop_req = inst_valid & inst_ready;
    assign pop     = pop_req & ~redirect;
    // A return that coincides with a redirect belongs to the old stream.
    assign push    = inflight_q & ~redirect;

`ifdef FETCH_HALT_EN
    assign halt_hit = push & (mem_data[24:20] == HALT_OPCODE);
    assign halted   = (state_q == StHalt);
`else
    assign halt_hit = 1'b0;
    assign halted   = 1'b0;
`endif

    // Credit: entries held plus the one in flight, less the one leaving now,
    // must leave room for another return. This keeps pushes off a full FIFO.
    assign occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop_req};

    // A returning HALT word also blocks the read that would follow it.
    assign mem_rd = (state_q == StRun) & ~redirect & ~halt_hit & (occupancy < DEPTH_C);

    always_comb begin
        state_d = state_q;
        if (redirect) begin
            state_d = fetch_en ? StRun : StIdle;
        end else begin
            case (state_q)
                StIdle:  if (fetch_en) state_d = StRun;
                StRun: begin
                    if (!fetch_en)     state_d = StIdle;
                    else if (halt_hit) state_d = StHalt;
                end
                StHalt:  state_d = StHalt;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pc_q       <= RESET_PC;
            tag_q      <= '0;
            inflight_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data_q[i] <= '0;
                fifo_pc_q[i]   <= '0;
            end
        end else if (redirect) begin
            pc_q       <= redirect_pc;
            inflight_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            if (mem_rd) begin
                pc_q  <= pc_q + 8'd1;
                tag_q <= pc_q;
            end
            inflight_q <= mem_rd;
            if (push) begin
                fifo_data_q[wr_ptr_q] <= mem_data;
                fifo_pc_q[wr_ptr_q]   <= tag_q;
                wr_ptr_q              <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        Reset_n;
    logic        fetch_en;
    logic [7:0]  mem_addr;
    logic        mem_rd;
    logic [24:0] mem_data = '0;
    logic        inst_valid;
    logic        inst_ready;
    logic [24:0] inst_data;
    logic [7:0]  inst_pc;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic        halted;

    // Second instance with a reset PC near the top of the address space.
    logic        fetch_en_b;
    logic [7:0]  mem_addr_b;
    logic        mem_rd_b;
    logic [24:0] mem_data_b = '0;
    logic        inst_valid_b;
    logic [24:0] inst_data_b;
    logic [7:0]  inst_pc_b;
    logic        halted_b;

    logic        halt_test;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    inst_fetch_unit dut (
        .clk         (clk),
        .Reset_n     (Reset_n),
        .fetch_en    (fetch_en),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst_data   (inst_data),
        .inst_pc     (inst_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halted      (halted)
    );

    inst_fetch_unit #(
        .RESET_PC (8'hFE)
    ) dut_b (
        .clk         (clk),
        .Reset_n     (Reset_n),
        .fetch_en    (fetch_en_b),
        .mem_addr    (mem_addr_b),
        .mem_rd      (mem_rd_b),
        .mem_data    (mem_data_b),
        .inst_valid  (inst_valid_b),
        .inst_ready  (1'b1),
        .inst_data   (inst_data_b),
        .inst_pc     (inst_pc_b),
        .redirect    (1'b0),
        .redirect_pc (8'h00),
        .halted      (halted_b)
    );

    // Address-tagged memory contents; address 05 becomes a HALT word on request.
    function automatic logic [24:0] word(input logic [7:0] a, input logic halt_sel);
        if (halt_sel && a == 8'h05) return {5'b11111, 4'h0, 4'h0, 4'h0, a};
        return {5'h02, 4'h3, a[7:4], a[3:0], a};
    endfunction

    always @(posedge clk) begin
        if (mem_rd)   mem_data   <= word(mem_addr, halt_test);
        if (mem_rd_b) mem_data_b <= word(mem_addr_b, 1'b0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset_n     = 1'b0;
        fetch_en    = 1'b0;
        fetch_en_b  = 1'b0;
        inst_ready  = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 8'h00;
        halt_test   = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_valid",  inst_valid, 0);
        chk("rst_rd",     mem_rd, 0);
        chk("rst_addr",   mem_addr, 8'h00);
        chk("rst_data",   inst_data, 0);
        chk("rst_pc",     inst_pc, 0);
        chk("rst_halted", halted, 0);
        chk("rst_addr_b", mem_addr_b, 8'hFE);
        Reset_n = 1'b1;
        @(negedge clk);
        chk("idle_rd", mem_rd, 0);

        // Streaming from reset; instance b wraps FE, FF, 00 ...
        fetch_en   = 1'b1;
        fetch_en_b = 1'b1;
        inst_ready = 1'b1;
        @(negedge clk);
        chk("run_rd", mem_rd, 1);
        chk("run_addr", mem_addr, 8'h00);
        chk("run_valid0", inst_valid, 0);
        @(negedge clk);
        chk("run_valid1", inst_valid, 0);
        chk("run_addr1", mem_addr, 8'h01);
        @(negedge clk);
        chk("first_valid", inst_valid, 1);
        chk("first_pc", inst_pc, 8'h00);
        chk("first_data", inst_data, word(8'h00, 1'b0));
        chk("wrap_pc_b0", inst_pc_b, 8'hFE);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            chk("stream_valid", inst_valid, 1);
            chk("stream_pc", inst_pc, 8'(i));
            chk("stream_data", inst_data, word(8'(i), 1'b0));
            chk("wrap_pc_b", inst_pc_b, 8'(8'hFE + 8'(i)));
        end
        fetch_en_b = 1'b0;

        // Backpressure: FIFO fills to its depth, head holds, reads stop
        inst_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_valid", inst_valid, 1);
            chk("hold_pc", inst_pc, 8'h05);
            chk("hold_data", inst_data, word(8'h05, 1'b0));
        end
        chk("full_rd", mem_rd, 0);
        chk("full_addr", mem_addr, 8'h09);
        inst_ready = 1'b1;
        #1;
        chk("release_rd", mem_rd, 1);
        for (int i = 6; i <= 10; i++) begin
            @(negedge clk);
            chk("drain_valid", inst_valid, 1);
            chk("drain_pc", inst_pc, 8'(i));
        end

        // Redirect with entries buffered and a read in flight
        redirect    = 1'b1;
        redirect_pc = 8'h40;
        #1;
        chk("redir_rd", mem_rd, 0);
        @(negedge clk);
        redirect = 1'b0;
        #1;
        chk("redir_valid", inst_valid, 0);
        chk("redir_rd_new", mem_rd, 1);
        chk("redir_addr", mem_addr, 8'h40);
        @(negedge clk);
        chk("redir_stale", inst_valid, 0);
        @(negedge clk);
        chk("redir_v40", inst_valid, 1);
        chk("redir_pc40", inst_pc, 8'h40);
        chk("redir_d40", inst_data, word(8'h40, 1'b0));
        @(negedge clk);
        chk("redir_pc41", inst_pc, 8'h41);
        @(negedge clk);
        chk("redir_pc42", inst_pc, 8'h42);
        chk("run_halted", halted, 0);

        // Asynchronous reset with the FIFO full
        inst_ready = 1'b0;
        repeat (6) @(negedge clk);
        chk("prerst_rd", mem_rd, 0);
        chk("prerst_pc", inst_pc, 8'h42);
        Reset_n = 1'b0;
        #1;
        chk("arst_valid", inst_valid, 0);
        chk("arst_rd", mem_rd, 0);
        chk("arst_addr", mem_addr, 8'h00);
        chk("arst_pc", inst_pc, 0);
        @(negedge clk);
        fetch_en = 1'b0;
        Reset_n  = 1'b1;
        @(negedge clk);
        chk("postrst_valid", inst_valid, 0);
        fetch_en   = 1'b1;
        inst_ready = 1'b1;
        @(negedge clk);
        chk("postrst_addr", mem_addr, 8'h00);
        chk("postrst_valid0", inst_valid, 0);
        @(negedge clk);
        chk("postrst_valid1", inst_valid, 0);
        @(negedge clk);
        chk("postrst_first", inst_pc, 8'h00);
        chk("postrst_v", inst_valid, 1);
        @(negedge clk);
        chk("postrst_second", inst_pc, 8'h01);

`ifdef FETCH_HALT_EN
        // HALT word at address 05
        Reset_n   = 1'b0;
        fetch_en  = 1'b0;
        halt_test = 1'b1;
        @(negedge clk);
        Reset_n = 1'b1;
        @(negedge clk);
        fetch_en   = 1'b1;
        inst_ready = 1'b1;
        @(negedge clk);
        chk("halt_run_addr", mem_addr, 8'h00);
        @(negedge clk);
        chk("halt_v0", inst_valid, 0);
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            chk("halt_stream_v", inst_valid, 1);
            chk("halt_stream_pc", inst_pc, 8'(k));
        end
        chk("halt_opcode", inst_data[24:20], 5'b11111);
        chk("halt_flag", halted, 1);
        chk("halt_rd", mem_rd, 0);
        @(negedge clk);
        chk("halt_empty", inst_valid, 0);
        repeat (3) @(negedge clk);
        chk("halt_rd_hold", mem_rd, 0);
        chk("halt_flag_hold", halted, 1);
        chk("halt_empty_hold", inst_valid, 0);
        redirect    = 1'b1;
        redirect_pc = 8'h10;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        chk("unhalt_flag", halted, 0);
        chk("unhalt_rd", mem_rd, 1);
        chk("unhalt_addr", mem_addr, 8'h10);
        @(negedge clk);
        chk("unhalt_v0", inst_valid, 0);
        @(negedge clk);
        chk("unhalt_pc10", inst_pc, 8'h10);
        @(negedge clk);
        chk("unhalt_pc11", inst_pc, 8'h11);
`else
        chk("nohalt_flag", halted, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
